// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status lines of the boot loader.
// The loader is the slave; the boot source / system side is the master.
interface imem_loader_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_last;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_stall;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   word_count;

   modport master (
      output start, in_valid, in_data, in_last,
      input  in_ready, imem_we, imem_addr, imem_wdata, core_stall, done, err, word_count
   );

   modport slave (
      input  start, in_valid, in_data, in_last,
      output in_ready, imem_we, imem_addr, imem_wdata, core_stall, done, err, word_count
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: assembles little-endian bytes into words, screens opcodes, writes imem
// while stalling the core. All outputs are decoded from registered state only.
module imem_loader #(
   parameter int unsigned ADDR_W = 10
) (
   input logic          clk,
   input logic          rst_n,
   imem_loader_if.slave bus
);
   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StLoad   = 3'd1;
   localparam logic [2:0] StWrite  = 3'd2;
   localparam logic [2:0] StFinish = 3'd3;
   localparam logic [2:0] StError  = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [31:0]     word_q, word_d;
   logic [1:0]      idx_q, idx_d;
   logic            last_q, last_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic            legal;
   logic            full;

   always_comb begin
      legal = 1'b0;
      case (word_q[6:0])
         7'b0000000, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
         7'b1100011, 7'b1100111, 7'b1101111, 7'b0010111: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   // The extra count bit is set exactly when every word slot has been written.
   assign full = cnt_q[ADDR_W];

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle, StError: begin
            if (bus.start) begin
               state_d = StLoad;
               word_d  = '0;
               idx_d   = '0;
               last_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         StLoad: begin
            if (bus.in_valid) begin
               word_d[{idx_q, 3'b000} +: 8] = bus.in_data;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = StWrite;
                  last_d  = bus.in_last;
               end else if (bus.in_last) begin
                  state_d = StError;
               end
            end
         end
         StWrite: begin
            if (full || !legal) begin
               state_d = StError;
            end else begin
               cnt_d   = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
               state_d = last_q ? StFinish : StLoad;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         word_q  <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready   = (state_q == StLoad);
   assign bus.imem_we    = (state_q == StWrite) && !full && legal;
   assign bus.imem_addr  = cnt_q[ADDR_W-1:0];
   assign bus.imem_wdata = word_q;
   assign bus.core_stall = (state_q != StIdle);
   assign bus.done       = (state_q == StFinish);
   assign bus.err        = (state_q == StError);
   assign bus.word_count = cnt_q;
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle RISC-V core. Accepts a little-endian byte stream over a valid/ready handshake and assembles it into 32-bit instruction words. Writes each word into instruction memory while holding the core stalled. Screens every word's opcode against the set the core's control decoder supports, so the decoder never sees an opcode it cannot handle.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction-memory word-address width; depth = 2^ADDR_W words.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: one-cycle pulse that begins a load session; honoured only in IDLE or ERROR.
- `in_valid` in 1: byte available.
- `in_data` in 8: stream byte.
- `in_last` in 1: qualifies the final byte of the program.
- `in_ready` out 1: loader accepts a byte this cycle.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out ADDR_W: word address.
- `imem_wdata` out 32: instruction word.
- `core_stall` out 1: holds core PC/regfile while high.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: sticky error flag; cleared only by `start` or reset.
- `word_count` out ADDR_W+1: number of words written in the current or last session.

## Operation
- Legal opcodes (`word[6:0]`): 0000000 (NoP), 0110011 (R), 0010011 (addi), 0000011 (lw), 0100011 (sw), 1100011 (branch), 1100111 (jalr), 1101111 (jal), 0010111 (auipc). Any other opcode is illegal.
- States: IDLE, LOAD, WRITE, FINISH, ERROR.
- IDLE: `in_ready`=0, `core_stall`=0. On `start`, go to LOAD and clear address, `word_count`, byte index and `err`.
- LOAD: `in_ready`=1, `core_stall`=1. A byte is accepted when `in_valid & in_ready`.
  - Byte index k (0..3) goes to `word[8k+7:8k]`, so byte 0 is the LSB.
  - Accepting byte index 3: go to WRITE and latch `in_last`.
  - `in_last` on byte index 0..2 (partial word): go to ERROR; nothing is written.
- WRITE: `in_ready`=0. Checks are applied in this priority order:
  1. `word_count` == 2^ADDR_W (memory full): ERROR, no write.
  2. Illegal opcode: ERROR, no write.
  3. Otherwise: `imem_we`=1 for exactly this cycle, then the address increments and `word_count` increments. Next state is FINISH if the latched last flag is set, else LOAD.
- FINISH: `done`=1 for one cycle, `core_stall`=1, then IDLE. `core_stall` drops on entering IDLE.
- ERROR: `err`=1, `core_stall`=1, `in_ready`=0. The state is held until `start`, which behaves as the IDLE→LOAD transition.
- `start` in LOAD, WRITE or FINISH is ignored.
- Address arithmetic: `imem_addr` is the low ADDR_W bits of `word_count` and never wraps. Overflow is caught by the memory-full check before any write.

## Timing
- Reset (`rst_n`=0 at a rising edge): state IDLE, all outputs 0, `imem_addr`=0, `word_count`=0, assembly register 0. Reset mid-session abandons the partial word; no write is issued in the reset cycle.
- All outputs are registered or decoded from the state register only. There is no combinational path from `in_valid`/`in_data` to any output.
- `start` at edge N: `in_ready`=1 from cycle N+1.
- Fourth byte accepted at edge M: `imem_we` high in cycle M+1, `in_ready` low in cycle M+1, `in_ready` high again in cycle M+2.
- Peak throughput is 4 bytes per 5 cycles. Gaps in `in_valid` stall assembly without losing bytes.
- The last word is written in cycle W. `done` is high in cycle W+1, and `core_stall` is low from cycle W+2.
- `word_count` updates on the edge that ends the WRITE cycle.

## Test plan
- Basic load: `start`, then bytes 93 00 50 00 (`in_last` on 00) → one `imem_we`, addr 0, data 0x00500093. `done` pulse two cycles after the write edge, `word_count`=1, `err`=0.
- Multi-word with gaps: 3 words 0x00500093, 0x002081B3, 0x0000006F with random `in_valid` bubbles → writes at addr 0,1,2 with exact data, `word_count`=3. No byte dropped or duplicated.
- Illegal opcode: word 0x0000007F → no `imem_we`, `err`=1 and held, `core_stall`=1. A following `start` clears `err` and reloads successfully.
- Partial word: 3 bytes with `in_last` on the third → ERROR, `imem_we` never asserted, `word_count`=0.
- Overflow with `ADDR_W`=2: 5 legal words → addresses 0..3 written, fifth not written, `err`=1, `word_count`=4.
- Reset mid-load: `rst_n` low after 2 bytes of word 1 → all outputs 0 next cycle. A new session writes its first word at addr 0.
